fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_unpack.sv | 28 ++
 rtl/fp_mul_seq.sv | 160 ++++++++++++++++
 tb/tb_fp_mul_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float types and constants for the sequential FP units.
// Used by fp_mul_seq, fp_unpack and any sibling divider.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_NORM,
        ST_PACK
    } state_e;

    localparam int          FP_BIAS = 127;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF  = 32'h7F80_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] man;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpack: field split, hidden-bit insertion and
// classification. Denormals are reported as zero (flush-to-zero).
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] f_i,
    output logic        sign_o,
    output logic [7:0]  exp_o,
    output logic [23:0] man_o,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o
);

    logic exp_all_ones;
    logic frac_nonzero;

    assign exp_all_ones = (f_i[30:23] == 8'hFF);
    assign frac_nonzero = (f_i[22:0] != 23'd0);

    assign sign_o    = f_i[31];
    assign exp_o     = f_i[30:23];
    assign man_o     = {1'b1, f_i[22:0]};
    assign is_zero_o = (f_i[30:23] == 8'h00);
    assign is_inf_o  = exp_all_ones && !frac_nonzero;
    assign is_nan_o  = exp_all_ones && frac_nonzero;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: 24-cycle shift-add, fixed 27-cycle
// start-to-done latency. Define FP_MUL_RNE_EN for round-to-nearest-even, else truncate.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int LAT = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ia,
    input  logic [31:0] ib,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    localparam int              MUL_CYCLES = LAT - 3;
    localparam logic [4:0]      MUL_LAST   = 5'(MUL_CYCLES - 1);
    localparam logic signed [9:0] BIAS_S   = 10'(FP_BIAS);

    state_e              state_q, state_d;
    logic [31:0]         a_q, b_q;
    logic                sign_q;
    logic signed [9:0]   exp_q;
    logic [23:0]         ma_q, mb_q;
    logic [47:0]         prod_q;
    logic [4:0]          cnt_q;
    logic                nan_q, inf_q, zero_q;
    logic [31:0]         out_q, out_d;
    logic                done_q;

    fp_unpacked_t        ua, ub;

    fp_unpack u_unpack_a (
        .f_i       (a_q),
        .sign_o    (ua.sign),
        .exp_o     (ua.exp),
        .man_o     (ua.man),
        .is_zero_o (ua.is_zero),
        .is_inf_o  (ua.is_inf),
        .is_nan_o  (ua.is_nan)
    );

    fp_unpack u_unpack_b (
        .f_i       (b_q),
        .sign_o    (ub.sign),
        .exp_o     (ub.exp),
        .man_o     (ub.man),
        .is_zero_o (ub.is_zero),
        .is_inf_o  (ub.is_inf),
        .is_nan_o  (ub.is_nan)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MUL;
            ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_NORM;
            ST_NORM: state_d = ST_PACK;
            ST_PACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Pack: round, renormalise a mantissa carry-out, then saturate to Inf/zero.
    logic [23:0]       man_sel;
    logic              round_up;
    logic [24:0]       man_rnd;
    logic signed [9:0] exp_fin;
    logic [22:0]       frac_fin;

    always_comb begin
        man_sel  = prod_q[46:23];
`ifdef FP_MUL_RNE_EN
        round_up = prod_q[22] & (prod_q[21] | (|prod_q[20:0]) | man_sel[0]);
`else
        round_up = 1'b0;
`endif
        man_rnd  = {1'b0, man_sel} + {24'd0, round_up};
        exp_fin  = exp_q + $signed({9'd0, man_rnd[24]});
        frac_fin = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];

        out_d = {sign_q, exp_fin[7:0], frac_fin};
        if (nan_q)                    out_d = FP_QNAN;
        else if (inf_q)               out_d = {sign_q, FP_INF[30:0]};
        else if (zero_q)              out_d = {sign_q, 31'd0};
        else if (exp_fin >= 10'sd255) out_d = {sign_q, FP_INF[30:0]};
        else if (exp_fin <= 10'sd0)   out_d = {sign_q, 31'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            sign_q <= 1'b0;
            exp_q  <= 10'sd0;
            ma_q   <= 24'd0;
            mb_q   <= 24'd0;
            prod_q <= 48'd0;
            cnt_q  <= 5'd0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
            out_q  <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q <= ia;
                        b_q <= ib;
                    end
                end
                ST_LOAD: begin
                    sign_q <= ua.sign ^ ub.sign;
                    exp_q  <= $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - BIAS_S;
                    ma_q   <= ua.man;
                    mb_q   <= ub.man;
                    prod_q <= 48'd0;
                    cnt_q  <= 5'd0;
                    // Inf*0 is invalid and shares the NaN result.
                    nan_q  <= ua.is_nan | ub.is_nan |
                              (ua.is_inf & ub.is_zero) | (ub.is_inf & ua.is_zero);
                    inf_q  <= ua.is_inf | ub.is_inf;
                    zero_q <= ua.is_zero | ub.is_zero;
                end
                ST_MUL: begin
                    if (mb_q[cnt_q])
                        prod_q <= prod_q + ({24'd0, ma_q} << cnt_q);
                    cnt_q <= (cnt_q == MUL_LAST) ? 5'd0 : cnt_q + 5'd1;
                end
                ST_NORM: begin
                    // Keep the shifted-out bit as sticky so rounding still sees it.
                    if (prod_q[47]) begin
                        prod_q <= {1'b0, prod_q[47:2], prod_q[1] | prod_q[0]};
                        exp_q  <= exp_q + 10'sd1;
                    end
                end
                ST_PACK: begin
                    out_q  <= out_d;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: latency, products, special cases, rounding,
// ignored re-start and mid-operation reset.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ia, ib;
    logic [31:0] out;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    fp_mul_seq #(.LAT(27)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ia    (ia),
        .ib    (ib),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: called #1 after a rising edge. Returns product, edges from the
    // accepting edge to done, busy just after accept, and done one cycle later.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat,
                          output logic busy_after, output logic done_next);
        ia = a; ib = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_after = busy;
        lat = 0;
        while (lat < 40) begin
            if (lat > 0 || done) begin end
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        res = out;
        @(posedge clk); #1;
        done_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ia = 32'd0; ib = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        total++; if (out !== 32'd0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out, 32'd0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] r; int lat; logic ba, dn;
        // start is already high on the first edge after reset release
        run_op(32'h42D2_0000, 32'h4254_0000, r, lat, ba, dn);
        total++; if (r !== 32'h45AD_E800) begin bad++; $display("FAIL mul_105x53 got=%h exp=%h", r, 32'h45AD_E800); end
        total++; if (lat !== 27) begin bad++; $display("FAIL latency got=%0d exp=27", lat); end
        total++; if (ba !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b exp=1", ba); end
        total++; if (dn !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", dn); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_products();
        logic [31:0] va[5] = '{32'h41C8_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7F00_0000, 32'hBF80_0000};
        logic [31:0] vb[5] = '{32'h4248_0000, 32'h4120_0000, 32'h0000_0000, 32'h7F00_0000, 32'h4000_0000};
        logic [31:0] ve[5] = '{32'h449C_4000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'hC000_0000};
        logic [31:0] r; int lat; logic ba, dn;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], r, lat, ba, dn);
            total++; if (r !== ve[i]) begin bad++; $display("FAIL product_%0d got=%h exp=%h", i, r, ve[i]); end
            total++; if (lat !== 27) begin bad++; $display("FAIL product_lat_%0d got=%0d exp=27", i, lat); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] r, e; int lat; logic ba, dn;
`ifdef FP_MUL_RNE_EN
        e = 32'h3FC0_0002;
`else
        e = 32'h3FC0_0001;
`endif
        run_op(32'h3FC0_0000, 32'h3F80_0001, r, lat, ba, dn);
        total++; if (r !== e) begin bad++; $display("FAIL rounding got=%h exp=%h", r, e); end
        total++; if (lat !== 27) begin bad++; $display("FAIL rounding_lat got=%0d exp=27", lat); end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        held = out;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++; if (out !== held) begin bad++; $display("FAIL hold_out_%0d got=%h exp=%h", i, out, held); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_done_%0d got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_restart_ignored();
        int n; int extra;
        ia = 32'h41C8_0000; ib = 32'h4248_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 40) begin
            if (n == 4) begin ia = 32'h4000_0000; ib = 32'h4040_0000; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        start = 1'b0;
        total++; if (n !== 27) begin bad++; $display("FAIL restart_lat got=%0d exp=27", n); end
        total++; if (out !== 32'h449C_4000) begin bad++; $display("FAIL restart_out got=%h exp=%h", out, 32'h449C_4000); end
        extra = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL restart_queued got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r; int lat; logic ba, dn;
        ia = 32'hBF80_0000; ib = 32'h4000_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (out !== 32'd0) begin bad++; $display("FAIL midrst_out got=%h exp=%h", out, 32'd0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(32'h42D2_0000, 32'h4254_0000, r, lat, ba, dn);
        total++; if (r !== 32'h45AD_E800) begin bad++; $display("FAIL postrst_out got=%h exp=%h", r, 32'h45AD_E800); end
        total++; if (lat !== 27) begin bad++; $display("FAIL postrst_lat got=%0d exp=27", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_rounding();
        test_hold();
        test_restart_ignored();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
